post_collector: RTL and testbench

Write-back end of the post-processing path: accepts the row stream leaving the post-processing stage (POX 16-bit words per beat, one beat per cycle) and reassembles POY consecutive rows into a full POY×POX output tile. Tiles are tagged with their channel index and presented to the output feature-map buffer over a valid/ready handshake. Two tile buffers (ping-pong) let a new tile fill while the previous one waits for the consumer.

---
 rtl/post_collector_pkg.sv | 18 +
 rtl/post_tile_buf.sv | 80 ++++++++
 rtl/post_collector.sv | 120 ++++++++++++
 tb/tb_post_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/post_collector_pkg.sv
// Shared definitions for the post_collector write-back path: word width,
// index-width helper and the per-tile-buffer state encoding.
package post_collector_pkg;

  localparam int WORD_W = 16;

  // Width of an index over n items, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_e;

endpackage

// File: rtl/post_tile_buf.sv
// One POY x POX tile buffer: row-addressed register storage plus the
// EMPTY/FILLING/FULL occupancy state and the channel tag of the held tile.
module post_tile_buf
  import post_collector_pkg::*;
#(
  parameter int POX  = 3,
  parameter int POY  = 3,
  parameter int CH_W = 1,
  localparam int ROW_W = POX * WORD_W,
  localparam int RW    = ch_w(POY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ROW_W-1:0]        wr_data,
  input  logic [RW-1:0]           wr_row,
  input  logic [CH_W-1:0]         wr_tag,
  input  logic                    rd_ack,
  output logic                    full,
  output logic [POY*ROW_W-1:0]    tile,
  output logic [CH_W-1:0]         tag
);

  logic [ROW_W-1:0] rows [POY];
  buf_state_e       state_q;
  buf_state_e       state_d;
  logic             last_row;

  assign last_row = (wr_row == RW'(POY - 1));

  // Row storage carries no reset; occupancy state decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rows[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      tag     <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en && last_row) begin
        tag <= wr_tag;
      end
    end
  end

  // A write and an ack never target the same buffer in one cycle: writes
  // need a non-FULL buffer and acks need a FULL one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, FILLING: begin
        if (wr_en) begin
          state_d = last_row ? FULL : FILLING;
        end
      end
      FULL: begin
        if (rd_ack) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    full = (state_q == FULL);
  end

  always_comb begin
    tile = '0;
    for (int y = 0; y < POY; y++) begin
      tile[y*ROW_W +: ROW_W] = rows[y];
    end
  end

endmodule

// File: rtl/post_collector.sv
// Reassembles POY consecutive post-processing rows into channel-tagged tiles
// using two ping-pong tile buffers. Define POST_COLLECTOR_STATS_EN to enable
// the handshake counter on tile_count.
module post_collector
  import post_collector_pkg::*;
#(
  parameter int POX       = 3,
  parameter int POY       = 3,
  parameter int CHANNEL_N = 2,
  localparam int CH_W   = ch_w(CHANNEL_N),
  localparam int ROW_W  = POX * WORD_W,
  localparam int TILE_W = POY * ROW_W,
  localparam int RW     = ch_w(POY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  post_in,
  input  logic              post_in_valid,
  output logic [TILE_W-1:0] tile_out,
  output logic [CH_W-1:0]   tile_ch,
  output logic              tile_out_valid,
  input  logic              tile_out_ready,
  output logic              overflow,
  output logic [15:0]       tile_count
);

  logic [RW-1:0]     wr_row;
  logic [CH_W-1:0]   wr_ch;
  logic              wr_sel;
  logic              rd_sel;

  logic              buf_full [2];
  logic [TILE_W-1:0] buf_tile [2];
  logic [CH_W-1:0]   buf_tag  [2];

  logic              accept;
  logic              drop;
  logic              last_row;
  logic              handshake;

  // A buffer freed by this cycle's handshake still reads FULL here, so a
  // beat aimed at it is dropped rather than written.
  assign accept    = post_in_valid && !buf_full[wr_sel];
  assign drop      = post_in_valid &&  buf_full[wr_sel];
  assign last_row  = (wr_row == RW'(POY - 1));
  assign handshake = tile_out_valid && tile_out_ready;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    post_tile_buf #(
      .POX  (POX),
      .POY  (POY),
      .CH_W (CH_W)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (wr_sel == 1'(g))),
      .wr_data (post_in),
      .wr_row  (wr_row),
      .wr_tag  (wr_ch),
      .rd_ack  (handshake && (rd_sel == 1'(g))),
      .full    (buf_full[g]),
      .tile    (buf_tile[g]),
      .tag     (buf_tag[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row <= '0;
      wr_ch  <= '0;
      wr_sel <= 1'b0;
    end else if (accept) begin
      if (last_row) begin
        wr_row <= '0;
        wr_sel <= ~wr_sel;
        wr_ch  <= (wr_ch == CH_W'(CHANNEL_N - 1)) ? '0 : wr_ch + 1'b1;
      end else begin
        wr_row <= wr_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel <= 1'b0;
    end else if (handshake) begin
      rd_sel <= ~rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Buffer contents are unreset, so the tile bus is masked until valid.
  assign tile_out_valid = buf_full[rd_sel];
  assign tile_out       = tile_out_valid ? buf_tile[rd_sel] : '0;
  assign tile_ch        = tile_out_valid ? buf_tag[rd_sel]  : '0;

`ifdef POST_COLLECTOR_STATS_EN
  logic [15:0] hs_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_count <= '0;
    end else if (handshake) begin
      hs_count <= hs_count + 16'd1;
    end
  end

  assign tile_count = hs_count;
`else
  assign tile_count = '0;
`endif

endmodule

// File: tb/tb_post_collector.sv
// Bench for post_collector: directed scenarios plus randomized traffic,
// compared every cycle against a two-entry tile-queue model.
module tb_post_collector;

  localparam int POX       = 3;
  localparam int POY       = 3;
  localparam int CHANNEL_N = 2;
  localparam int W         = 16;
  localparam int ROW_W     = POX * W;
  localparam int TILE_W    = POY * ROW_W;

`ifdef POST_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ROW_W-1:0]  post_in = '0;
  logic              post_in_valid = 1'b0;
  logic [TILE_W-1:0] tile_out;
  logic [0:0]        tile_ch;
  logic              tile_out_valid;
  logic              tile_out_ready = 1'b0;
  logic              overflow;
  logic [15:0]       tile_count;

  int checks   = 0;
  int failures = 0;

  post_collector #(
    .POX       (POX),
    .POY       (POY),
    .CHANNEL_N (CHANNEL_N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .post_in        (post_in),
    .post_in_valid  (post_in_valid),
    .tile_out       (tile_out),
    .tile_ch        (tile_ch),
    .tile_out_valid (tile_out_valid),
    .tile_out_ready (tile_out_ready),
    .overflow       (overflow),
    .tile_count     (tile_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed tiles sit in a queue of at most two; a beat is lost
  // when two tiles were already waiting at the start of the cycle.
  typedef struct {
    logic [TILE_W-1:0] d;
    int                ch;
  } tile_t;

  tile_t             q[$];
  logic [TILE_W-1:0] m_part;
  int                m_rows;
  int                m_ch;
  bit                m_ovf;
  int                m_cnt;

  always @(posedge clk) begin : model
    int pend;
    if (rst) begin
      q.delete();
      m_part = '0;
      m_rows = 0;
      m_ch   = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      pend = q.size();
      if (pend > 0 && tile_out_ready) begin
        q.delete(0);
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (post_in_valid) begin
        if (pend == 2) begin
          m_ovf = 1'b1;
        end else begin
          m_part[m_rows*ROW_W +: ROW_W] = post_in;
          m_rows++;
          if (m_rows == POY) begin
            q.push_back('{m_part, m_ch});
            m_ch   = (m_ch + 1) % CHANNEL_N;
            m_rows = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (!rst) begin
      chk("valid", TILE_W'(tile_out_valid), TILE_W'(q.size() > 0));
      if (q.size() > 0) begin
        chk("tile_out", tile_out, q[0].d);
        chk("tile_ch", TILE_W'(tile_ch), TILE_W'(q[0].ch));
      end
      chk("overflow", TILE_W'(overflow), TILE_W'(m_ovf));
      chk("tile_count", TILE_W'(tile_count), STATS ? TILE_W'(m_cnt) : '0);
    end
  end

  function automatic logic [ROW_W-1:0] make_row(input int base);
    logic [ROW_W-1:0] r;
    for (int x = 0; x < POX; x++) begin
      r[x*W +: W] = W'(base + x);
    end
    return r;
  endfunction

  task automatic cyc(input logic v, input logic r, input logic [ROW_W-1:0] d);
    post_in_valid  = v;
    tile_out_ready = r;
    post_in        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", TILE_W'(tile_out_valid), '0);
    chk("rst_tile", tile_out, '0);
    chk("rst_ch", TILE_W'(tile_ch), '0);
    chk("rst_ovf", TILE_W'(overflow), '0);
    chk("rst_cnt", TILE_W'(tile_count), '0);

    // First tile: words 1..9, valid one cycle after row 3
    cyc(1'b1, 1'b1, make_row(1));
    cyc(1'b1, 1'b1, make_row(4));
    chk("t1_not_yet", TILE_W'(tile_out_valid), '0);
    cyc(1'b1, 1'b1, make_row(7));
    chk("t1_valid", TILE_W'(tile_out_valid), TILE_W'(1));
    chk("t1_row0", TILE_W'(tile_out[ROW_W-1:0]), TILE_W'(48'h0003_0002_0001));
    chk("t1_row2", TILE_W'(tile_out[3*ROW_W-1:2*ROW_W]), TILE_W'(48'h0009_0008_0007));
    chk("t1_ch", TILE_W'(tile_ch), '0);
    cyc(1'b0, 1'b1, '0);

    // 12 back-to-back rows with ready held high
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, make_row(100 + 3 * i));
    cyc(1'b0, 1'b1, '0);
    chk("b2b_ovf", TILE_W'(overflow), '0);
    chk("b2b_cnt", TILE_W'(tile_count), STATS ? TILE_W'(4) : '0);

    // Consumer stalled for 7 rows: two tiles held, 7th row dropped
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, make_row(1 + 3 * i));
    chk("stall_ovf", TILE_W'(overflow), TILE_W'(1));
    chk("stall_ch0", TILE_W'(tile_ch), '0);
    chk("stall_row0", TILE_W'(tile_out[ROW_W-1:0]), TILE_W'(48'h0003_0002_0001));
    cyc(1'b0, 1'b1, '0);
    chk("stall_ch1", TILE_W'(tile_ch), TILE_W'(1));
    chk("stall_t2row0", TILE_W'(tile_out[ROW_W-1:0]), TILE_W'(48'h000c_000b_000a));
    cyc(1'b0, 1'b1, '0);
    chk("stall_drained", TILE_W'(tile_out_valid), '0);

    // Last row of buffer B coincides with handoff of buffer A
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, make_row(1 + 3 * i));
    cyc(1'b1, 1'b1, make_row(16));
    chk("sim_valid", TILE_W'(tile_out_valid), TILE_W'(1));
    chk("sim_ch", TILE_W'(tile_ch), TILE_W'(1));
    chk("sim_row0", TILE_W'(tile_out[ROW_W-1:0]), TILE_W'(48'h000c_000b_000a));
    chk("sim_ovf", TILE_W'(overflow), '0);
    cyc(1'b0, 1'b1, '0);

    // Reset mid-tile, then a fresh channel-0 tile
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, make_row(50 + 3 * i));
    do_reset();
    chk("mid_valid", TILE_W'(tile_out_valid), '0);
    chk("mid_tile", tile_out, '0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, make_row(200 + 3 * i));
    chk("mid_ch", TILE_W'(tile_ch), '0);
    chk("mid_row0", TILE_W'(tile_out[ROW_W-1:0]), TILE_W'(48'h00ca_00c9_00c8));
    cyc(1'b0, 1'b1, '0);

    // Randomized traffic, including stalls that provoke overflow
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [ROW_W-1:0] d;
      logic             v;
      logic             r;
      d = {$urandom(), $urandom()};
      v = ($urandom_range(0, 3) != 0);
      r = (i < 300) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      cyc(v, r, d);
    end
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
